seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_pkg.sv | 16 +
 rtl/seg_scan_if.sv | 29 ++
 rtl/seg_scan_timer.sv | 47 ++++
 rtl/seg_scan_driver.sv | 91 +++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed 8-digit seven-segment scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;

  typedef logic [2:0] digit_idx_t;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the game logic and the scan driver: digit patterns and controls in, panel lines out.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic [SEG_W-1:0]      SEG0;
  logic [SEG_W-1:0]      SEG1;
  logic [SEG_W-1:0]      SEG2;
  logic [SEG_W-1:0]      SEG3;
  logic [SEG_W-1:0]      SEG4;
  logic [SEG_W-1:0]      SEG5;
  logic [SEG_W-1:0]      SEG6;
  logic [SEG_W-1:0]      SEG7;
  logic [NUM_DIGITS-1:0] blink;
  logic [2:0]            brightness;
  logic [SEG_W-1:0]      seg_out;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  frame_start;

  modport master (
    output SEG0, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG7, blink, brightness,
    input  seg_out, digit_sel, frame_start
  );

  modport slave (
    input  SEG0, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG7, blink, brightness,
    output seg_out, digit_sel, frame_start
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Scan timebase: slot counter, digit index, frame boundary strobe and blink phase.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [$clog2(DIV)-1:0] cnt,
  output digit_idx_t             idx,
  output logic                   frame_boundary,
  output logic                   bp
);

  localparam int CNT_W = $clog2(DIV);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic            slot_end;
  logic [FC_W-1:0] fcnt;

  assign slot_end       = (cnt == CNT_W'(DIV - 1));
  assign frame_boundary = slot_end && (idx == digit_idx_t'(NUM_DIGITS - 1));

  // idx is exactly three bits wide, so it wraps from 7 to 0 on its own
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      fcnt <= '0;
      bp   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        idx <= idx + 1'b1;
      if (frame_boundary) begin
        if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
          fcnt <= '0;
          bp   <= ~bp;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit LED driver: frame-latched patterns, anti-ghost blanking,
// PWM brightness and per-digit blink, all with registered panel outputs.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIV          = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input logic     clk,
  input logic     rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]      cnt;
  digit_idx_t            idx;
  logic                  frame_boundary;
  logic                  bp;
  logic [2:0]            ph;
  logic [SEG_W-1:0]      seg_in       [NUM_DIGITS];
  logic [SEG_W-1:0]      shadow_seg   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_blink;
  logic                  shadow_bp;
  logic                  lit;
  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  fs_q;

  seg_scan_timer #(
    .DIV          (DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .cnt            (cnt),
    .idx            (idx),
    .frame_boundary (frame_boundary),
    .bp             (bp)
  );

  assign seg_in[0] = bus.SEG0;
  assign seg_in[1] = bus.SEG1;
  assign seg_in[2] = bus.SEG2;
  assign seg_in[3] = bus.SEG3;
  assign seg_in[4] = bus.SEG4;
  assign seg_in[5] = bus.SEG5;
  assign seg_in[6] = bus.SEG6;
  assign seg_in[7] = bus.SEG7;

  // The blink phase is captured with the patterns so each frame is blanked uniformly
  always_ff @(posedge clk) begin
    if (rst) begin
      ph           <= '0;
      shadow_blink <= '0;
      shadow_bp    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        shadow_seg[i] <= '0;
    end else begin
      ph <= ph + 1'b1;
      if (frame_boundary) begin
        shadow_blink <= bus.blink;
        shadow_bp    <= bp;
        for (int i = 0; i < NUM_DIGITS; i++)
          shadow_seg[i] <= seg_in[i];
      end
    end
  end

  assign lit = (cnt >= CNT_W'(BLANK_CYC)) &&
               (ph <= bus.brightness) &&
               !(shadow_blink[idx] && shadow_bp);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      sel_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= lit ? shadow_seg[idx] : '0;
      sel_q <= lit ? digit_onehot(idx) : '0;
      fs_q  <= frame_boundary;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_start = fs_q;

endmodule
